// File: rtl/pm1_pkg.sv
// Shared widths, FSM state encoding and fail-reason codes for the Pollard p-1 sequencer.
package pm1_pkg;

    localparam int N_W = 64;
    localparam int E_W = 65;
    localparam int B_W = 8;

    localparam logic [B_W-1:0] BOUND_MAX = '1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EF_REQ,
        ST_EF_WAIT,
        ST_ME_REQ,
        ST_ME_WAIT,
        ST_GD_REQ,
        ST_GD_WAIT,
        ST_DECIDE,
        ST_DONE
    } pm1_state_e;

    typedef enum logic [2:0] {
        FR_NONE,
        FR_TRIVIAL,
        FR_BOUND_EXHAUSTED,
        FR_BASES_EXHAUSTED,
        FR_TIMEOUT
    } pm1_fail_e;

endpackage

// File: rtl/pm1_controller_if.sv
// Handshake bundle between the p-1 sequencer and its e_finder, modexp and gcd units.
interface pm1_controller_if;
    import pm1_pkg::*;

    logic           ef_start;
    logic [B_W-1:0] ef_boundary;
    logic [E_W-1:0] ef_e;
    logic           ef_done;

    logic           me_start;
    logic [N_W-1:0] me_base;
    logic [E_W-1:0] me_exp;
    logic [N_W-1:0] me_mod;
    logic [N_W-1:0] me_result;
    logic           me_done;

    logic           gd_start;
    logic [N_W-1:0] gd_a;
    logic [N_W-1:0] gd_b;
    logic [N_W-1:0] gd_result;
    logic           gd_done;

    modport master (
        output ef_start, ef_boundary, input ef_e, ef_done,
        output me_start, me_base, me_exp, me_mod, input me_result, me_done,
        output gd_start, gd_a, gd_b, input gd_result, gd_done
    );

    modport slave (
        input ef_start, ef_boundary, output ef_e, ef_done,
        input me_start, me_base, me_exp, me_mod, output me_result, me_done,
        input gd_start, gd_a, gd_b, output gd_result, gd_done
    );

endinterface

// File: rtl/pm1_watchdog.sv
// Wait-state cycle counter for the p-1 sequencer; only built when PM1_TIMEOUT_EN is defined.
`ifdef PM1_TIMEOUT_EN
module pm1_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // The count reaches TIMEOUT_CYCLES-1 during the last tolerated wait cycle.
    assign o_expired = i_count && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/pm1_controller.sv
// Pollard p-1 sequencer: g = gcd(a^e - 1 mod n, n), then report, widen the bound or change base.
// Optional wait-state watchdog and timeout port enabled by PM1_TIMEOUT_EN.
module pm1_controller
    import pm1_pkg::*;
#(
    parameter int MAX_BASES = 4
`ifdef PM1_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_W-1:0]  n_in,
    input  logic [B_W-1:0]  bound_init,
    input  logic [B_W-1:0]  bound_step,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic [N_W-1:0]  factor,
`ifdef PM1_TIMEOUT_EN
    output logic            timeout,
`endif
    pm1_controller_if.master bus
);

    pm1_state_e     r_state, w_next;
    pm1_fail_e      r_reason;
    logic [N_W-1:0] r_n, r_a, r_d, r_g, r_factor;
    logic [E_W-1:0] r_e;
    logic [B_W-1:0] r_bound, r_step;
    logic [7:0]     r_base_cnt;
    logic           r_done, r_busy;

    logic w_n_small, w_n_even, w_g_proper, w_g_one, w_bound_top, w_bases_out, w_x_one;
    logic w_wd_hit;

    function automatic logic [B_W-1:0] sat_add_bound(input logic [B_W-1:0] b,
                                                     input logic [B_W-1:0] s);
        logic [B_W:0] sum;
        sum = {1'b0, b} + {1'b0, (s == '0) ? B_W'(1) : s};
        return sum[B_W] ? BOUND_MAX : sum[B_W-1:0];
    endfunction

    assign w_n_small   = r_n < N_W'(4);
    assign w_n_even    = ~r_n[0];
    assign w_g_proper  = (r_g > N_W'(1)) && (r_g < r_n);
    assign w_g_one     = r_g == N_W'(1);
    assign w_bound_top = r_bound == BOUND_MAX;
    assign w_bases_out = (r_base_cnt + 8'd1) == 8'(MAX_BASES);
    assign w_x_one     = bus.me_result == N_W'(1);

`ifdef PM1_TIMEOUT_EN
    logic w_in_req, w_in_wait;
    assign w_in_req  = (r_state == ST_EF_REQ) || (r_state == ST_ME_REQ) || (r_state == ST_GD_REQ);
    assign w_in_wait = (r_state == ST_EF_WAIT) || (r_state == ST_ME_WAIT) || (r_state == ST_GD_WAIT);

    pm1_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_in_req),
        .i_count   (w_in_wait),
        .o_expired (w_wd_hit)
    );

    assign timeout = r_done && (r_reason == FR_TIMEOUT);
`else
    assign w_wd_hit = 1'b0;
`endif

    // Starts decode straight from state so an async reset removes them immediately.
    assign bus.ef_start    = (r_state == ST_EF_REQ);
    assign bus.ef_boundary = r_bound;
    assign bus.me_start    = (r_state == ST_ME_REQ);
    assign bus.me_base     = r_a;
    assign bus.me_exp      = r_e;
    assign bus.me_mod      = r_n;
    assign bus.gd_start    = (r_state == ST_GD_REQ);
    assign bus.gd_a        = r_d;
    assign bus.gd_b        = r_n;

    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_done && (r_reason == FR_NONE);
    assign factor = r_factor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (start) w_next = ST_CHECK;
            ST_CHECK:   w_next = (w_n_small || w_n_even) ? ST_DONE : ST_EF_REQ;
            ST_EF_REQ:  w_next = ST_EF_WAIT;
            ST_EF_WAIT: begin
                if (bus.ef_done)   w_next = ST_ME_REQ;
                else if (w_wd_hit) w_next = ST_DONE;
            end
            ST_ME_REQ:  w_next = ST_ME_WAIT;
            ST_ME_WAIT: begin
                if (bus.me_done)   w_next = w_x_one ? ST_DECIDE : ST_GD_REQ;
                else if (w_wd_hit) w_next = ST_DONE;
            end
            ST_GD_REQ:  w_next = ST_GD_WAIT;
            ST_GD_WAIT: begin
                if (bus.gd_done)   w_next = ST_DECIDE;
                else if (w_wd_hit) w_next = ST_DONE;
            end
            ST_DECIDE: begin
                if (w_g_proper)   w_next = ST_DONE;
                else if (w_g_one) w_next = w_bound_top ? ST_DONE : ST_EF_REQ;
                else              w_next = w_bases_out ? ST_DONE : ST_ME_REQ;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_a        <= '0;
            r_d        <= '0;
            r_g        <= '0;
            r_e        <= '0;
            r_factor   <= '0;
            r_bound    <= '0;
            r_step     <= '0;
            r_base_cnt <= '0;
            r_reason   <= FR_NONE;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (start) begin
                    r_n        <= n_in;
                    r_bound    <= bound_init;
                    r_step     <= bound_step;
                    r_a        <= N_W'(2);
                    r_base_cnt <= '0;
                    r_factor   <= '0;
                    r_reason   <= FR_NONE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b1;
                end
                ST_CHECK: begin
                    if (w_n_small)     r_reason <= FR_TRIVIAL;
                    else if (w_n_even) r_factor <= N_W'(2);
                end
                ST_EF_WAIT: begin
                    if (bus.ef_done)            r_e      <= bus.ef_e;
                    else if (w_next == ST_DONE) r_reason <= FR_TIMEOUT;
                end
                ST_ME_WAIT: begin
                    if (bus.me_done) begin
                        // x == 1 means gcd(0, n) = n, so the gcd unit is skipped.
                        if (w_x_one)                   r_g <= r_n;
                        else if (bus.me_result == '0)  r_d <= r_n - N_W'(1);
                        else                           r_d <= bus.me_result - N_W'(1);
                    end else if (w_next == ST_DONE) begin
                        r_reason <= FR_TIMEOUT;
                    end
                end
                ST_GD_WAIT: begin
                    if (bus.gd_done)            r_g      <= bus.gd_result;
                    else if (w_next == ST_DONE) r_reason <= FR_TIMEOUT;
                end
                ST_DECIDE: begin
                    if (w_g_proper) begin
                        r_factor <= r_g;
                    end else if (w_g_one) begin
                        if (w_bound_top) r_reason <= FR_BOUND_EXHAUSTED;
                        else             r_bound  <= sat_add_bound(r_bound, r_step);
                    end else begin
                        r_base_cnt <= r_base_cnt + 8'd1;
                        if (w_bases_out) r_reason <= FR_BASES_EXHAUSTED;
                        else             r_a      <= r_a + N_W'(1);
                    end
                end
                default: ;
            endcase

            if (w_next == ST_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

endmodule
